// File: rtl/mem_access_unit.sv
// Load/store unit between EX and the data memory: range check, a fixed-latency
// strobe window, and a held load response towards writeback.
module mem_access_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req_valid,
  output logic        out_req_ready,
  input  logic        in_req_write,
  input  logic [31:0] in_req_addr,
  input  logic [31:0] in_req_data,
  input  logic [5:0]  in_req_rd,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic [31:0] out_mem_addr,
  output logic [31:0] out_mem_data,
  input  logic [31:0] in_mem_rdata,
  output logic        out_resp_valid,
  output logic [31:0] out_resp_data,
  output logic [5:0]  out_resp_rd,
  output logic        out_resp_err,
  input  logic        in_resp_ready,
  output logic        out_store_done,
  output logic        out_stall
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 6;

  typedef enum logic [1:0] {IDLE, ACCESS, ERR, RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write;
  logic                r_err;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [RD_W-1:0]     r_rd;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_store_done;

  logic w_accept;
  logic w_addr_err;
  logic w_final;

  assign w_accept   = in_req_valid && (r_state == IDLE);
  assign w_addr_err = (in_req_addr[31:16] != 16'h0000);
  assign w_final    = (r_state == ACCESS) && (r_cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_addr_err ? ERR : ACCESS;
      ACCESS:  if (w_final) w_next = r_write ? IDLE : RESP;
      ERR:     w_next = RESP;
      RESP:    if (in_resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, latency counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rd         <= '0;
      r_resp_data  <= '0;
      r_store_done <= 1'b0;
    end else begin
      r_store_done <= w_final && r_write;
      if (w_accept) begin
        r_write <= in_req_write;
        r_err   <= w_addr_err;
        r_addr  <= in_req_addr;
        r_data  <= in_req_data;
        r_rd    <= in_req_rd;
        r_cnt   <= CNT_W'(MEM_LATENCY - 1);
      end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_final && !r_write) r_resp_data <= in_mem_rdata;
      else if (r_state == ERR) r_resp_data <= '0;
    end
  end

  // Outputs decode the registered state; only the stall term looks at in_req_valid
  assign out_req_ready  = (r_state == IDLE);
  assign out_mem_read   = (r_state == ACCESS) && !r_write;
  assign out_mem_write  = (r_state == ACCESS) && r_write;
  assign out_mem_addr   = r_addr;
  assign out_mem_data   = r_data;
  assign out_resp_valid = (r_state == RESP);
  assign out_resp_err   = (r_state == RESP) && r_err;
  assign out_resp_data  = r_resp_data;
  assign out_resp_rd    = r_rd;
  assign out_store_done = r_store_done;
  assign out_stall      = (r_state != IDLE) ||
                          (in_req_valid && (r_state == IDLE) && (w_next != IDLE));

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (latency 1 and 3) driven by directed
// and random transactions, checked against a transaction-level memory model.
module tb_mem_access_unit;

  logic              clk;
  logic [1:0]        rst, req_valid, req_ready, req_write;
  logic [1:0]        mem_read, mem_write, resp_valid, resp_err, resp_ready;
  logic [1:0]        store_done, stall;
  logic [1:0][31:0]  req_addr, req_data, mem_addr, mem_wdata, mem_rdata, resp_data;
  logic [1:0][5:0]   req_rd, resp_rd;

  logic [31:0] env_mem [2][1024];
  logic [31:0] ref_mem [2][1024];

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst[0]), .in_req_valid(req_valid[0]), .out_req_ready(req_ready[0]),
    .in_req_write(req_write[0]), .in_req_addr(req_addr[0]), .in_req_data(req_data[0]),
    .in_req_rd(req_rd[0]), .out_mem_read(mem_read[0]), .out_mem_write(mem_write[0]),
    .out_mem_addr(mem_addr[0]), .out_mem_data(mem_wdata[0]), .in_mem_rdata(mem_rdata[0]),
    .out_resp_valid(resp_valid[0]), .out_resp_data(resp_data[0]), .out_resp_rd(resp_rd[0]),
    .out_resp_err(resp_err[0]), .in_resp_ready(resp_ready[0]),
    .out_store_done(store_done[0]), .out_stall(stall[0]));

  mem_access_unit #(.MEM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst[1]), .in_req_valid(req_valid[1]), .out_req_ready(req_ready[1]),
    .in_req_write(req_write[1]), .in_req_addr(req_addr[1]), .in_req_data(req_data[1]),
    .in_req_rd(req_rd[1]), .out_mem_read(mem_read[1]), .out_mem_write(mem_write[1]),
    .out_mem_addr(mem_addr[1]), .out_mem_data(mem_wdata[1]), .in_mem_rdata(mem_rdata[1]),
    .out_resp_valid(resp_valid[1]), .out_resp_data(resp_data[1]), .out_resp_rd(resp_rd[1]),
    .out_resp_err(resp_err[1]), .in_resp_ready(resp_ready[1]),
    .out_store_done(store_done[1]), .out_stall(stall[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by each instance; word i initially holds i
  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1024; i++) begin
        env_mem[k][i] = 32'(i);
        ref_mem[k][i] = 32'(i);
      end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_write[k]) env_mem[k][mem_addr[k][9:0]] <= mem_wdata[k];
  end

  assign mem_rdata[0] = env_mem[0][mem_addr[0][9:0]];
  assign mem_rdata[1] = env_mem[1][mem_addr[1][9:0]];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_ctl(input int k, input string ph, input logic rd, input logic wr,
                         input logic rv, input logic er, input logic rdy,
                         input logic stl, input logic sd);
    check($sformatf("%s%0d.mem_read", ph, k),   32'(mem_read[k]),   32'(rd));
    check($sformatf("%s%0d.mem_write", ph, k),  32'(mem_write[k]),  32'(wr));
    check($sformatf("%s%0d.resp_valid", ph, k), 32'(resp_valid[k]), 32'(rv));
    check($sformatf("%s%0d.resp_err", ph, k),   32'(resp_err[k]),   32'(er));
    check($sformatf("%s%0d.req_ready", ph, k),  32'(req_ready[k]),  32'(rdy));
    check($sformatf("%s%0d.stall", ph, k),      32'(stall[k]),      32'(stl));
    check($sformatf("%s%0d.store_done", ph, k), 32'(store_done[k]), 32'(sd));
  endtask

  // One request from an IDLE negedge until the unit is IDLE again; junk=1 keeps
  // a different request asserted while busy, which must not be taken.
  task automatic txn(input int k, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [5:0] rd,
                     input int delay, input logic junk);
    int          busy;
    logic        err;
    logic [31:0] exp_data;
    err  = (addr[31:16] != 16'h0000);
    busy = err ? 1 : lat(k);
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = addr;
    req_data[k]  = data; req_rd[k]    = rd; resp_ready[k] = 1'b0;
    #1;
    chk_ctl(k, "accept", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    if (junk) begin
      req_write[k] = 1'b0; req_addr[k] = 32'($urandom_range(0, 1023));
    end else begin
      req_valid[k] = 1'b0;
    end
    for (int c = 0; c < busy; c++) begin
      #1;
      chk_ctl(k, "busy", !err && !wr, !err && wr, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (!err) begin
        check($sformatf("busy%0d.mem_addr", k), mem_addr[k], addr);
        if (wr) check($sformatf("busy%0d.mem_data", k), mem_wdata[k], data);
      end
      @(negedge clk);
    end
    if (wr && !err) begin
      req_valid[k] = 1'b0;
      ref_mem[k][addr[9:0]] = data;
      #1;
      chk_ctl(k, "stdone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check($sformatf("stdone%0d.mem_addr", k), mem_addr[k], addr);
      @(negedge clk);
      #1;
      chk_ctl(k, "post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      exp_data = err ? 32'h0 : ref_mem[k][addr[9:0]];
      for (int c = 0; c <= delay; c++) begin
        resp_ready[k] = (c == delay);
        #1;
        chk_ctl(k, "resp", 1'b0, 1'b0, 1'b1, err, 1'b0, 1'b1, 1'b0);
        check($sformatf("resp%0d.data", k), resp_data[k], exp_data);
        check($sformatf("resp%0d.rd", k), 32'(resp_rd[k]), 32'(rd));
        check($sformatf("resp%0d.mem_addr", k), mem_addr[k], addr);
        @(negedge clk);
      end
      req_valid[k] = 1'b0; resp_ready[k] = 1'b0;
      #1;
      chk_ctl(k, "post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int          k;
    logic        wr;
    logic [31:0] addr;
    rst = 2'b11; req_valid = 2'b11; req_write = 2'b00; resp_ready = 2'b00;
    req_addr = '0; req_data = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    // Request held during reset must not be taken
    rst = 2'b00; req_valid = 2'b00;
    #1;
    for (int j = 0; j < 2; j++) begin
      chk_ctl(j, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("reset%0d.resp_data", j), resp_data[j], 32'h0);
      check($sformatf("reset%0d.resp_rd", j), 32'(resp_rd[j]), 32'h0);
      check($sformatf("reset%0d.mem_addr", j), mem_addr[j], 32'h0);
    end
    @(negedge clk);
    #1;
    check("reset0.not_taken", 32'(req_ready[0]), 32'h1);
    check("reset1.not_taken", 32'(req_ready[1]), 32'h1);

    txn(0, 1'b0, 32'h0000_0100, 32'h0, 6'h15, 0, 1'b0);
    txn(0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 6'h01, 0, 1'b0);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 6'h02, 0, 1'b0);
    txn(0, 1'b0, 32'h0001_0000, 32'h0, 6'h3F, 0, 1'b0);
    txn(1, 1'b0, 32'h0000_0033, 32'h0, 6'h2A, 4, 1'b1);
    txn(1, 1'b1, 32'h0000_0044, 32'h1234_5678, 6'h05, 0, 1'b1);
    txn(1, 1'b0, 32'h0000_0044, 32'h0, 6'h06, 1, 1'b0);

    // Reset in the second strobe cycle of a latency-3 load
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h40; req_rd[1] = 6'h11;
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    check("rstmid.strobe1", 32'(mem_read[1]), 32'h1);
    @(negedge clk);
    check("rstmid.strobe2", 32'(mem_read[1]), 32'h1);
    rst[1] = 1'b1;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk_ctl(1, "rstmid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rstmid.no_resp", 32'(resp_valid[1]), 32'h0);
      check("rstmid.no_strobe", 32'(mem_read[1]), 32'h0);
    end
    resp_ready[1] = 1'b0;

    for (int n = 0; n < 80; n++) begin
      k    = n % 2;
      wr   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) addr[31:16] = 16'($urandom_range(1, 65535));
      txn(k, wr, addr, $urandom, 6'($urandom), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 1, meaning the number of cycles the memory strobe is held per access (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port in_req_valid  input  1  EX stage presents a memory request.
REQ-005 The block SHALL have port out_req_ready  output  1  the unit accepts a request this cycle.
REQ-006 The block SHALL have port in_req_write  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port in_req_addr  input  32  word address.
REQ-008 The block SHALL have port in_req_data  input  32  store data.
REQ-009 The block SHALL have port in_req_rd  input  6  load destination register tag.
REQ-010 The block SHALL have ports out_mem_read  output  1  and out_mem_write  output  1, the data-memory read and write strobes.
REQ-011 The block SHALL have ports out_mem_addr  output  32  and out_mem_data  output  32, driven to the data memory.
REQ-012 The block SHALL have port in_mem_rdata  input  32  data-memory read data.
REQ-013 The block SHALL have ports out_resp_valid  output  1, out_resp_data  output  32, out_resp_rd  output  6, out_resp_err  output  1, the load response to writeback.
REQ-014 The block SHALL have port in_resp_ready  input  1  writeback consumes the response.
REQ-015 The block SHALL have ports out_store_done  output  1  (one-cycle pulse per completed store) and out_stall  output  1  (pipeline hold).

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, ERR, RESP.
REQ-017 In IDLE, out_req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-018 A request SHALL be accepted on a rising edge with in_req_valid=1 and out_req_ready=1; write, addr, data and rd are then latched.
REQ-019 An accepted request with in_req_addr[31:16] != 0 SHALL go to ERR, with no memory strobe ever asserted for it.
REQ-020 An accepted in-range request SHALL go to ACCESS and load a latency counter with MEM_LATENCY-1.
REQ-021 In ACCESS, exactly one of out_mem_read/out_mem_write SHALL be 1, per the latched write bit, and out_mem_addr/out_mem_data SHALL hold the latched values stable.
REQ-022 In ACCESS, the counter SHALL decrement each cycle; the cycle with counter=0 is the final strobe cycle.
REQ-023 On the final strobe cycle of a load, in_mem_rdata SHALL be captured and the state SHALL become RESP.
REQ-024 On the final strobe cycle of a store, the state SHALL become IDLE, and out_store_done SHALL be 1 for exactly the next cycle.
REQ-025 ERR SHALL last one cycle and then go to RESP, with data=0 and err=1.
REQ-026 In RESP, out_resp_valid SHALL be 1, with data, rd and err held stable until a rising edge with in_resp_ready=1, after which the state SHALL become IDLE.
REQ-027 Outside RESP, out_resp_valid and out_resp_err SHALL be 0.
REQ-028 Outside ACCESS, both strobes SHALL be 0, and out_mem_addr/out_mem_data SHALL retain their last latched values.
REQ-029 out_stall SHALL equal (state != IDLE) OR (in_req_valid AND state == IDLE AND the next state is not IDLE), and SHALL be registered-state based with no combinational path from in_resp_ready.
REQ-030 Latency: a load with MEM_LATENCY=L and in_resp_ready held at 1 SHALL occupy L+2 cycles from accept to IDLE, with out_resp_valid asserted in cycle L+1 after accept.
REQ-031 A request presented while not in IDLE SHALL NOT be accepted; the requester holds it.

Reset
REQ-032 When rst=1 on an edge, the state SHALL become IDLE and the counter SHALL become 0.
REQ-033 Reset SHALL set all outputs to 0 except out_req_ready, which SHALL be 1 in the first cycle after reset.
REQ-034 Reset mid-operation SHALL abandon the in-flight request with no response and no store_done pulse; a store whose strobe was already asserted is committed by the memory and is not rolled back.
REQ-035 A request presented with rst=1 SHALL NOT be accepted.

Verification
REQ-036 Scenario: load addr 0x100 with L=1 and resp_ready=1, memory returning 0x100 -> read strobe for 1 cycle, resp_valid in cycle 2 with data 0x100, err 0 and rd echoed, then ready=1 in cycle 3.
REQ-037 Scenario: store 0xDEADBEEF to 0x20, then load 0x20 -> write strobe with the stable addr/data, then store_done pulse, then load response 0xDEADBEEF.
REQ-038 Scenario: load addr 0x00010000 -> no strobe; resp_valid with err=1 and data 0, two cycles after accept.
REQ-039 Scenario: L=3 load with resp_ready=0 for 4 cycles -> read strobe for exactly 3 cycles; response held stable until the ready edge; req_ready=0 and stall=1 throughout.
REQ-040 Scenario: rst asserted during the second ACCESS cycle of an L=3 load -> strobes 0 and req_ready 1 the next cycle, and no resp_valid ever for that request.
